// File: rtl/device_b_responder_if.sv
// device_b_responder_if
//   Bundles the device-A to device-B transfer signals.
//   Handshake: four-phase request/acknowledge. Device A raises req_a with
//   data_in already stable and keeps both unchanged until ack_b is seen high.
//   It then drops req_a, and ack_b returns low before the next request may
//   start. hold is a local hold-off that is only honoured before a transfer
//   begins. data_valid pulses for one cycle when data_out is updated.
//   Signals:
//     req_a      A -> B  request, asynchronous to clk
//     data_in    A -> B  8-bit bundled data
//     hold       A -> B  synchronous hold-off
//     ack_b      B -> A  acknowledge
//     data_out   B -> A  last captured word
//     data_valid B -> A  one-cycle capture pulse
//     xfer_count B -> A  completed capture count (wraps)
//     err        B -> A  timeout error flag
//   Modports: master (device A / driver side), slave (responder).
interface device_b_responder_if;
  logic       req_a;
  logic [7:0] data_in;
  logic       hold;
  logic       ack_b;
  logic [7:0] data_out;
  logic       data_valid;
  logic [7:0] xfer_count;
  logic       err;

  modport master (
    output req_a, data_in, hold,
    input  ack_b, data_out, data_valid, xfer_count, err
  );

  modport slave (
    input  req_a, data_in, hold,
    output ack_b, data_out, data_valid, xfer_count, err
  );
endinterface

// File: rtl/device_b_responder.sv
// device_b_responder
//   Receiving side of a four-phase req/ack transfer from an asynchronous
//   device A. The request passes through a 2-flop synchronizer. After
//   ACK_DELAY cycles of sustained request the word on data_in is captured
//   and ack_b is raised. If device A does not release the request within
//   TIMEOUT cycles, ack_b drops and the block parks in an error state until
//   the request goes low.
//   Ports:
//     clk        system clock, rising edge
//     reset      asynchronous active-high reset
//     bus        device_b_responder_if.slave (req_a, data_in, hold in;
//                ack_b, data_out, data_valid, xfer_count, err out)
//     state_dbg  current FSM state (0 IDLE, 1 WAIT, 2 ACK, 3 ERR)
//   Parameters:
//     ACK_DELAY  1..15, cycles from synchronized request to ack
//     TIMEOUT    1..255, cycles ack may stay high awaiting release
module device_b_responder #(
  parameter int ACK_DELAY = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  device_b_responder_if.slave  bus,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [3:0] DLY_LAST = 4'(ACK_DELAY - 1);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  state_t     state;
  logic       req_s1;
  logic       req_s;
  logic [3:0] dly_cnt;
  logic [7:0] to_cnt;

  logic       ack_r;
  logic [7:0] data_r;
  logic       valid_r;
  logic [7:0] count_r;
  logic       err_r;

  // Two-flop synchronizer; only req_s is visible to the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_s1 <= 1'b0;
      req_s  <= 1'b0;
    end else begin
      req_s1 <= bus.req_a;
      req_s  <= req_s1;
    end
  end

  // Control FSM with registered outputs. data_in is only sampled on the
  // WAIT->ACK edge, so data_out holds between captures.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      dly_cnt <= 4'd0;
      to_cnt  <= 8'd0;
      ack_r   <= 1'b0;
      data_r  <= 8'h00;
      valid_r <= 1'b0;
      count_r <= 8'd0;
      err_r   <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state)
        S_IDLE: begin
          // hold is only consulted here; it cannot affect a transfer
          // that has already started.
          if (req_s && !bus.hold) begin
            state   <= S_WAIT;
            dly_cnt <= 4'd0;
          end
        end

        S_WAIT: begin
          if (!req_s) begin
            // Request withdrawn before the delay elapsed: abort silently.
            state <= S_IDLE;
          end else if (dly_cnt == DLY_LAST) begin
            state   <= S_ACK;
            ack_r   <= 1'b1;
            data_r  <= bus.data_in;
            count_r <= count_r + 8'd1;
            valid_r <= 1'b1;
            to_cnt  <= 8'd0;
          end else begin
            dly_cnt <= dly_cnt + 4'd1;
          end
        end

        S_ACK: begin
          // Release is tested first so it wins over a coincident timeout.
          if (!req_s) begin
            state <= S_IDLE;
            ack_r <= 1'b0;
          end else if (to_cnt == TO_LAST) begin
            state <= S_ERR;
            ack_r <= 1'b0;
            err_r <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end

        S_ERR: begin
          // Leaving through IDLE guarantees req_s is seen low before any
          // new transfer can start.
          if (!req_s) begin
            state <= S_IDLE;
            err_r <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          ack_r <= 1'b0;
          err_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack_b      = ack_r;
  assign bus.data_out   = data_r;
  assign bus.data_valid = valid_r;
  assign bus.xfer_count = count_r;
  assign bus.err        = err_r;
  assign state_dbg      = state;

endmodule

// File: doc/device_b_responder.md
DEVICE_B_RESPONDER -- requirements
Module: device_b_responder

Interface
REQ-001 Parameter: ACK_DELAY, default 4, cycles from synchronized request seen to ack assertion (legal 1..15).
REQ-002 Parameter: TIMEOUT, default 255, cycles ack may stay high waiting for request release (legal 1..255).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_a  input  1  request from device A; asynchronous to clk.
REQ-006 data_in  input  8  bundled data from device A, stable while req_a high.
REQ-007 hold  input  1  synchronous local hold-off; blocks new transfers.
REQ-008 ack_b  output  1  acknowledge to device A, registered.
REQ-009 data_out  output  8  last captured data word.
REQ-010 data_valid  output  1  one-cycle pulse on capture.
REQ-011 xfer_count  output  8  count of completed captures.
REQ-012 err  output  1  high while in timeout-error state.

Function
REQ-013 req_a SHALL pass through a 2-flop synchronizer; req_s (second flop output) is the only request the FSM sees.
REQ-014 FSM states SHALL be IDLE, WAIT, ACK, ERR; 4-bit delay counter and 8-bit timeout counter.
REQ-015 IDLE: req_s=1 and hold=0 -> WAIT, delay counter cleared to 0; otherwise stay.
REQ-016 WAIT: delay counter increments each cycle; req_s=0 -> IDLE, no capture, no ack (aborted request).
REQ-017 WAIT with counter = ACK_DELAY-1 and req_s=1 -> ACK; same edge: ack_b<=1, data_out<=data_in, xfer_count<=xfer_count+1, data_valid<=1, timeout counter <=0.
REQ-018 Ack latency: ack_b rises exactly ACK_DELAY+1 clk edges after the first edge on which req_s=1 in IDLE.
REQ-019 data_valid SHALL be high for exactly one cycle per capture; never asserted otherwise.
REQ-020 xfer_count SHALL wrap 255 -> 0 without flag.
REQ-021 ACK: ack_b held 1; req_s=0 -> IDLE with ack_b<=0 on same edge (four-phase return to zero).
REQ-022 ACK: timeout counter increments while req_s=1; at count = TIMEOUT-1 -> ERR, ack_b<=0, err<=1.
REQ-023 ERR: ack_b=0, err=1; req_s=0 -> IDLE with err<=0; no new transfer while in ERR.
REQ-024 req_s=0 and timeout simultaneously in ACK: release wins -> IDLE, err stays 0.
REQ-025 hold SHALL be sampled only in IDLE; hold rising in WAIT/ACK has no effect.
REQ-026 New transfer only from IDLE; req_s must be seen 0 then 1 again (returning to IDLE guarantees this).
REQ-027 data_out SHALL hold its value between captures; data_in never sampled outside REQ-017 edge.
REQ-028 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-029 reset=1 SHALL asynchronously force: state IDLE, sync flops 0, ack_b 0, data_out 0x00, data_valid 0, xfer_count 0, err 0, counters 0.
REQ-030 Reset mid-transfer (WAIT/ACK/ERR) SHALL drop ack_b immediately; after release, a still-high req_a starts a fresh transfer via the synchronizer.
REQ-031 Reset deassertion is assumed synchronized externally; block adds no reset synchronizer.

Verification
REQ-032 Basic: ACK_DELAY=4, req_a 0->1 with data_in=0xA5 -> ack_b high 7 edges after req_a edge (2 sync + 5), data_out=0xA5, one data_valid pulse, xfer_count=1; req_a low -> ack_b low 3 edges later.
REQ-033 Abort: req_a high for 3 cycles then low (ACK_DELAY=4) -> no ack_b, no data_valid, xfer_count unchanged.
REQ-034 Timeout: TIMEOUT=10, req_a held high -> ack_b high 10 cycles then low, err=1; req_a low -> err 0 three edges later; next request completes normally.
REQ-035 Hold: hold=1, req_a high -> ack_b stays 0; hold 0 -> transfer proceeds with normal latency.
REQ-036 Wrap: 256 back-to-back transfers, data_in=index -> xfer_count returns 0x00, data_out=0xFF.
REQ-037 Reset in ACK: assert reset while ack_b=1 -> ack_b, data_valid, xfer_count, data_out all 0 same cycle, asynchronously.
